uart_tx_buffer: RTL and testbench

Buffered UART transmitter downstream of the CPU's store path. Byte stores to the UART address are queued in a FIFO and serialized as 8N1 frames on uart_tx. The CPU is never stalled, and status (full/empty/count/overflow) is available for a memory-mapped status read. Replaces the direct unbuffered hookup of the core to the serializer.

---
 rtl/uart_tx_buffer_pkg.sv | 17 +
 rtl/uart_tx_buffer_sync_fifo.sv | 66 ++++++
 rtl/uart_tx_buffer.sv | 122 ++++++++++++
 tb/tb_uart_tx_buffer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the buffered UART transmitter: bus addresses,
// data width and the serializer state encoding.
package uart_tx_buffer_pkg;

  localparam int DATA_W = 8;

  localparam logic [31:0] UART_ADDR        = 32'h1000_0000;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h1000_0004;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Synchronous byte FIFO with registered occupancy count; a push into a full
// FIFO and a pop from an empty one are ignored.
module uart_tx_buffer_sync_fifo
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter: CPU byte stores are queued and serialized
// LSB first, with sticky overflow when a store hits a full queue.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 868
)(
  input  logic                   sysclk,
  input  logic                   cpu_reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   ovf_clr,
  output logic                   uart_tx,
  output logic                   busy,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              ovf_q;
  logic [7:0]        head_s;
  logic              pop_s;
  logic              bit_done_s;
  logic              drop_s;

  assign bit_done_s = (baud_q == BAUD_MAX);
  assign drop_s     = wr_en && fifo_full;
  // Pop on leaving IDLE, or at the end of STOP to chain frames without a gap.
  assign pop_s      = !fifo_empty &&
                      ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done_s));

  uart_tx_buffer_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (sysclk),
    .rst_i   (cpu_reset),
    .push_i  (wr_en),
    .data_i  (wr_data),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      baud_q <= ((state_q == ST_IDLE) || bit_done_s) ? '0 : baud_q + BAUD_W'(1);
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift_q <= head_s;
            state_q <= ST_START;
            tx_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done_s) begin
            state_q   <= ST_DATA;
            bit_idx_q <= 3'd0;
            tx_q      <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_done_s) begin
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end
        end
        ST_STOP: begin
          if (bit_done_s) begin
            if (!fifo_empty) begin
              shift_q <= head_s;
              state_q <= ST_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  // A dropped push outranks a clear in the same cycle.
  always_ff @(posedge sysclk) begin
    if (cpu_reset)    ovf_q <= 1'b0;
    else if (drop_s)  ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
    else              ovf_q <= ovf_q;
  end

  assign uart_tx  = tx_q;
  assign busy     = (state_q != ST_IDLE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer (DEPTH=4, CLKS_PER_BIT=4) with a
// line-side 8N1 receiver that collects every frame seen on uart_tx.
module tb_uart_tx_buffer;

  logic       sysclk = 1'b0;
  logic       cpu_reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       uart_tx;
  logic       busy;
  logic       fifo_full;
  logic       fifo_empty;
  logic [2:0] fifo_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int peak = 0;

  logic [7:0] rx_q[$];
  logic       rx_stop_q[$];
  int         rx_t0_q[$];

  uart_tx_buffer #(.DEPTH(4), .CLKS_PER_BIT(4)) dut (
    .sysclk     (sysclk),
    .cpu_reset  (cpu_reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .ovf_clr    (ovf_clr),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Receiver: samples on the falling edge, mid-bit relative to the start bit.
  initial begin : rx_mon
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge sysclk);
      if (uart_tx === 1'b0) begin
        t0 = cyc;
        repeat (2) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge sysclk);
          b[i] = uart_tx;
        end
        repeat (4) @(negedge sysclk);
        rx_q.push_back(b);
        rx_stop_q.push_back(uart_tx === 1'b1);
        rx_t0_q.push_back(t0);
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_stop_q.delete();
    rx_t0_q.delete();
  endtask

  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (rx_q.size() < n && k < 600) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 600) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    cpu_reset = 1'b1;
    repeat (3) tick();
    cpu_reset = 1'b0;
    checks++; if (uart_tx !== 1'b1)    begin errors++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0)  begin errors++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_single_byte();
    logic [9:0] fr;
    fr = {1'b1, 8'hA5, 1'b0};
    clear_rx();
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_after_push got=%0d exp=1", fifo_count); end
    checks++; if (uart_tx !== 1'b1)    begin errors++; $display("FAIL single_tx_before_pop got=%b exp=1", uart_tx); end
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++; if (uart_tx !== fr[k/4]) begin errors++; $display("FAIL single_line cyc=%0d got=%b exp=%b", k, uart_tx, fr[k/4]); end
      checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL single_busy cyc=%0d got=%b exp=1", k, busy); end
      if (k == 0) begin
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_after_pop got=%0d exp=0", fifo_count); end
      end
    end
    tick();
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL single_tx_end got=%b exp=1", uart_tx); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    int t_end;
    exp_b[0] = 8'h55; exp_b[1] = 8'h0F; exp_b[2] = 8'hFF;
    clear_rx();
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = exp_b[i];
      tick();
    end
    wr_en = 1'b0;
    wait_frames(3);
    checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL b2b_frames got=%0d exp=3", rx_q.size()); end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", i, rx_q[i], exp_b[i]); end
      checks++; if (rx_stop_q[i] !== 1'b1) begin errors++; $display("FAIL b2b_stop idx=%0d got=0 exp=1", i); end
      if (i > 0) begin
        checks++; if (rx_t0_q[i] - rx_t0_q[i-1] != 40) begin errors++; $display("FAIL b2b_gap idx=%0d got=%0d exp=40", i, rx_t0_q[i] - rx_t0_q[i-1]); end
      end
    end
    wait_idle();
    t_end = cyc;
    if (rx_t0_q.size() > 0) begin
      checks++; if (t_end - rx_t0_q[0] != 120) begin errors++; $display("FAIL b2b_total got=%0d exp=120", t_end - rx_t0_q[0]); end
    end
    checks++; if (peak != 2) begin errors++; $display("FAIL b2b_peak got=%0d exp=2", peak); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b [6];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    exp_b[3] = 8'h44; exp_b[4] = 8'h55; exp_b[5] = 8'h66;
    clear_rx();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = exp_b[i];
      tick();
    end
    checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (fifo_full !== 1'b1)  begin errors++; $display("FAIL ovf_full got=%b exp=1", fifo_full); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
    wr_data = 8'h77; ovf_clr = 1'b1;
    tick();
    wr_en = 1'b0; ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    wait_frames(5);
    repeat (60) tick();
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL ovf_frames got=%0d exp=5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_b[i]) begin errors++; $display("FAIL ovf_data idx=%0d got=%h exp=%h", i, rx_q[i], exp_b[i]); end
    end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL ovf_idle got=%b exp=0", busy); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got=%b exp=1", fifo_empty); end
    checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_b [5];
    exp_b[0] = 8'hA1; exp_b[1] = 8'hA2; exp_b[2] = 8'hA3;
    exp_b[3] = 8'hA4; exp_b[4] = 8'hA5;
    clear_rx();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = exp_b[i];
      tick();
    end
    wr_en = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ppf_count_full got=%0d exp=4", fifo_count); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL ppf_ovf_pre got=%b exp=0", overflow); end
    // The first frame's STOP ends 40 edges after its pop; push lands on that edge.
    repeat (36) tick();
    wr_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL ppf_ovf got=%b exp=1", overflow); end
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL ppf_count got=%0d exp=3", fifo_count); end
    checks++; if (uart_tx !== 1'b0)    begin errors++; $display("FAIL ppf_restart got=%b exp=0", uart_tx); end
    wait_frames(5);
    repeat (60) tick();
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL ppf_frames got=%0d exp=5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_b[i]) begin errors++; $display("FAIL ppf_data idx=%0d got=%h exp=%h", i, rx_q[i], exp_b[i]); end
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  task automatic test_mid_frame_reset();
    clear_rx();
    wr_en = 1'b1; wr_data = 8'hC3;
    tick();
    wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    repeat (17) tick();
    checks++; if (uart_tx !== 1'b0)    begin errors++; $display("FAIL mrst_bit3 got=%b exp=0", uart_tx); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL mrst_count_pre got=%0d exp=1", fifo_count); end
    cpu_reset = 1'b1;
    tick();
    cpu_reset = 1'b0;
    checks++; if (uart_tx !== 1'b1)    begin errors++; $display("FAIL mrst_tx got=%b exp=1", uart_tx); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL mrst_busy got=%b exp=0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mrst_count got=%0d exp=0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL mrst_empty got=%b exp=1", fifo_empty); end
    repeat (50) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_stay_idle got=%b exp=0", busy); end
    clear_rx();
    wr_en = 1'b1; wr_data = 8'h96;
    tick();
    wr_en = 1'b0;
    wait_frames(1);
    wait_idle();
    checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL mrst_frames got=%0d exp=1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      checks++; if (rx_q[0] !== 8'h96)     begin errors++; $display("FAIL mrst_data got=%h exp=96", rx_q[0]); end
      checks++; if (rx_stop_q[0] !== 1'b1) begin errors++; $display("FAIL mrst_stop got=0 exp=1"); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_push_pop_full();
    test_mid_frame_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
